// File: rtl/y_seq_detector.sv
`default_nettype none
// ============================================================================
//  Module   : y_seq_detector
//  Purpose  : Samples the serial Y bit from the two-T-flip-flop stage once per
//             strobe and detects a programmable bit pattern (overlapping or
//             non-overlapping). Emits a one-cycle match pulse, keeps a
//             saturating match count and exposes the recent bit history.
//  Ports    : clk       - system clock, rising edge
//             rst       - asynchronous reset, active-high
//             en        - sample strobe; y_in consumed only when en=1
//             y_in      - serial bit from the upstream stage
//             clr       - synchronous clear of match_cnt and cnt_sat
//             match     - one-clk pulse after the completing sample edge
//             match_cnt - saturating number of matches since reset/clr
//             cnt_sat   - sticky: a match arrived while match_cnt was max
//             hist      - last PAT_W sampled bits, LSB newest
//             filled    - window holds PAT_W valid bits (state RUN)
//  Revision : 1.0 - initial release
// ============================================================================
module y_seq_detector #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             y_in,
    input  logic             clr,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat,
    output logic [PAT_W-1:0] hist,
    output logic             filled
);

    localparam int                FILL_W      = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] C_FILL_LAST = FILL_W'(PAT_W - 1);
    localparam logic [FILL_W-1:0] C_FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  C_CNT_MAX   = '1;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    logic [FILL_W-1:0]   r_fill;
    logic [PAT_W-1:0]    r_hist;
    logic                r_match;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_sat;
    logic                r_filled;

    logic [PAT_W-1:0]    w_window;
    logic                w_valid;
    logic                w_hit;

    // Window as it will look once this sample is shifted in.
    assign w_window = {r_hist[PAT_W-2:0], y_in};
    // Stale or reset-zero bits must never produce a match: only compare when
    // this sample completes a full window of genuinely sampled bits.
    assign w_valid  = (r_state == ST_RUN) || (r_fill == C_FILL_LAST);
    assign w_hit    = en && w_valid && (w_window == PATTERN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_FILL;
            r_fill   <= '0;
            r_hist   <= '0;
            r_match  <= 1'b0;
            r_cnt    <= '0;
            r_sat    <= 1'b0;
            r_filled <= 1'b0;
        end else begin
            // Pulse only on the completing edge; every other edge clears it.
            r_match <= w_hit;

            if (en) begin
                r_hist <= w_window;
                if (w_hit && !OVERLAP) begin
                    // Non-overlapping: history restarts, previous bits unusable.
                    r_state  <= ST_FILL;
                    r_fill   <= '0;
                    r_filled <= 1'b0;
                end else begin
                    case (r_state)
                        ST_FILL: begin
                            if (r_fill == C_FILL_LAST) begin
                                r_state  <= ST_RUN;
                                r_fill   <= C_FILL_FULL;
                                r_filled <= 1'b1;
                            end else begin
                                r_fill <= r_fill + 1'b1;
                            end
                        end
                        ST_RUN: begin
                            r_state <= ST_RUN;
                        end
                        default: begin
                            r_state  <= ST_FILL;
                            r_fill   <= '0;
                            r_filled <= 1'b0;
                        end
                    endcase
                end
            end

            // clr takes priority over a coincident match for the counter.
            if (clr) begin
                r_cnt <= '0;
                r_sat <= 1'b0;
            end else if (w_hit) begin
                if (r_cnt == C_CNT_MAX) begin
                    r_sat <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign match     = r_match;
    assign match_cnt = r_cnt;
    assign cnt_sat   = r_sat;
    assign hist      = r_hist;
    assign filled    = r_filled;

endmodule
`default_nettype wire

// File: tb/tb_y_seq_detector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_y_seq_detector
//  Purpose  : Self-checking bench for y_seq_detector. Four instances share the
//             stimulus: default (1101, overlapping, 8-bit count), non-
//             overlapping, all-zero pattern, and 2-bit counter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_y_seq_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       y_in;
    logic       clr;

    logic       a_match, a_sat, a_filled;
    logic [7:0] a_cnt;
    logic [3:0] a_hist;
    logic       b_match, b_sat, b_filled;
    logic [7:0] b_cnt;
    logic [3:0] b_hist;
    logic       c_match, c_sat, c_filled;
    logic [7:0] c_cnt;
    logic [3:0] c_hist;
    logic       d_match, d_sat, d_filled;
    logic [1:0] d_cnt;
    logic [3:0] d_hist;

    int n_checks = 0;
    int n_fail   = 0;
    bit sb_q[$];

    always #5 clk = ~clk;

    y_seq_detector #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst), .en(en), .y_in(y_in), .clr(clr),
        .match(a_match), .match_cnt(a_cnt), .cnt_sat(a_sat), .hist(a_hist), .filled(a_filled));

    y_seq_detector #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(8)) u_b (
        .clk(clk), .rst(rst), .en(en), .y_in(y_in), .clr(clr),
        .match(b_match), .match_cnt(b_cnt), .cnt_sat(b_sat), .hist(b_hist), .filled(b_filled));

    y_seq_detector #(.PAT_W(4), .PATTERN(4'b0000), .OVERLAP(1'b1), .CNT_W(8)) u_c (
        .clk(clk), .rst(rst), .en(en), .y_in(y_in), .clr(clr),
        .match(c_match), .match_cnt(c_cnt), .cnt_sat(c_sat), .hist(c_hist), .filled(c_filled));

    y_seq_detector #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(2)) u_d (
        .clk(clk), .rst(rst), .en(en), .y_in(y_in), .clr(clr),
        .match(d_match), .match_cnt(d_cnt), .cnt_sat(d_sat), .hist(d_hist), .filled(d_filled));

    // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
    task automatic drive(input bit e, input bit y, input bit c);
        @(negedge clk);
        en   = e;
        y_in = y;
        clr  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        en   = 1'b0;
        y_in = 1'b0;
        clr  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] got;
        do_reset();
        #1;
        got = {a_match, a_sat, a_filled, a_cnt, a_hist, 1'b0};
        n_checks++;
        if (got !== 16'h0) begin n_fail++; $display("FAIL reset_a: got %h expected 0000", got); end
        got = {b_match, b_sat, b_filled, b_cnt, b_hist, 1'b0};
        n_checks++;
        if (got !== 16'h0) begin n_fail++; $display("FAIL reset_b: got %h expected 0000", got); end
        got = {c_match, c_sat, c_filled, c_cnt, c_hist, 1'b0};
        n_checks++;
        if (got !== 16'h0) begin n_fail++; $display("FAIL reset_c: got %h expected 0000", got); end
        got = {6'b0, d_match, d_sat, d_filled, d_cnt, d_hist, 1'b0};
        n_checks++;
        if (got !== 16'h0) begin n_fail++; $display("FAIL reset_d: got %h expected 0000", got); end
    endtask

    task automatic test_basic();
        logic [3:0] bits = 4'b1101;
        bit         exp_m;
        do_reset();
        for (int i = 3; i >= 0; i--) begin
            sb_q.push_back(i == 0);
            drive(1'b1, bits[i], 1'b0);
            exp_m = sb_q.pop_front();
            n_checks++;
            if (a_match !== exp_m) begin
                n_fail++; $display("FAIL basic_match bit%0d: got %b expected %b", 4 - i, a_match, exp_m);
            end
            if (i == 1) begin
                n_checks++;
                if (a_filled !== 1'b0) begin n_fail++; $display("FAIL basic_filled_early: got %b expected 0", a_filled); end
            end
        end
        n_checks++;
        if (a_cnt !== 8'd1) begin n_fail++; $display("FAIL basic_cnt: got %0d expected 1", a_cnt); end
        n_checks++;
        if (a_hist !== 4'b1101) begin n_fail++; $display("FAIL basic_hist: got %b expected 1101", a_hist); end
        n_checks++;
        if (a_filled !== 1'b1) begin n_fail++; $display("FAIL basic_filled: got %b expected 1", a_filled); end
        // en low: pulse must end after one clk and history must hold.
        drive(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (a_match !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width: got %b expected 0", a_match); end
        n_checks++;
        if (a_hist !== 4'b1101) begin n_fail++; $display("FAIL basic_hist_hold: got %b expected 1101", a_hist); end
    endtask

    task automatic test_overlap();
        logic [6:0] s  = 7'b1101101;
        logic [6:0] ea = 7'b0001001;
        logic [6:0] eb = 7'b0001000;
        bit         xa, xb;
        do_reset();
        for (int i = 6; i >= 0; i--) begin
            sb_q.push_back(ea[i]);
            sb_q.push_back(eb[i]);
            drive(1'b1, s[i], 1'b0);
            xa = sb_q.pop_front();
            xb = sb_q.pop_front();
            n_checks++;
            if (a_match !== xa) begin n_fail++; $display("FAIL overlap_match bit%0d: got %b expected %b", 7 - i, a_match, xa); end
            n_checks++;
            if (b_match !== xb) begin n_fail++; $display("FAIL nonoverlap_match bit%0d: got %b expected %b", 7 - i, b_match, xb); end
            if (i == 3) begin
                n_checks++;
                if (b_filled !== 1'b0) begin n_fail++; $display("FAIL nonoverlap_filled_after_match: got %b expected 0", b_filled); end
            end
        end
        n_checks++;
        if (a_cnt !== 8'd2) begin n_fail++; $display("FAIL overlap_cnt: got %0d expected 2", a_cnt); end
        n_checks++;
        if (b_cnt !== 8'd1) begin n_fail++; $display("FAIL nonoverlap_cnt: got %0d expected 1", b_cnt); end
        n_checks++;
        if (b_filled !== 1'b0) begin n_fail++; $display("FAIL nonoverlap_filled_end: got %b expected 0", b_filled); end
    endtask

    task automatic test_zero_pattern();
        logic [4:0] ec = 5'b00011;
        bit         xc;
        do_reset();
        for (int i = 4; i >= 0; i--) begin
            sb_q.push_back(ec[i]);
            drive(1'b1, 1'b0, 1'b0);
            xc = sb_q.pop_front();
            n_checks++;
            if (c_match !== xc) begin n_fail++; $display("FAIL zero_match bit%0d: got %b expected %b", 5 - i, c_match, xc); end
        end
        n_checks++;
        if (c_cnt !== 8'd2) begin n_fail++; $display("FAIL zero_cnt: got %0d expected 2", c_cnt); end
    endtask

    task automatic test_en_gating();
        logic [7:0] ev = 8'b10101010;
        logic [7:0] yv = 8'b10110011;
        logic [7:0] em = 8'b00000010;
        bit         xa;
        do_reset();
        for (int i = 7; i >= 0; i--) begin
            sb_q.push_back(em[i]);
            drive(ev[i], yv[i], 1'b0);
            xa = sb_q.pop_front();
            n_checks++;
            if (a_match !== xa) begin n_fail++; $display("FAIL engate_match clk%0d: got %b expected %b", 7 - i, a_match, xa); end
        end
        n_checks++;
        if (a_cnt !== 8'd1) begin n_fail++; $display("FAIL engate_cnt: got %0d expected 1", a_cnt); end
        n_checks++;
        if (a_hist !== 4'b1101) begin n_fail++; $display("FAIL engate_hist: got %b expected 1101", a_hist); end
    endtask

    task automatic test_saturation();
        logic [15:0] yv = 16'hDB6D;
        logic [15:0] em = 16'h1249;
        bit          xd;
        do_reset();
        for (int i = 15; i >= 0; i--) begin
            sb_q.push_back(em[i]);
            drive(1'b1, yv[i], i == 0);
            xd = sb_q.pop_front();
            n_checks++;
            if (d_match !== xd) begin n_fail++; $display("FAIL sat_match bit%0d: got %b expected %b", 16 - i, d_match, xd); end
            if (i == 6) begin
                n_checks++;
                if ({d_sat, d_cnt} !== 3'b011) begin n_fail++; $display("FAIL sat_third: got sat=%b cnt=%0d expected sat=0 cnt=3", d_sat, d_cnt); end
            end
            if (i == 3) begin
                n_checks++;
                if ({d_sat, d_cnt} !== 3'b111) begin n_fail++; $display("FAIL sat_fourth: got sat=%b cnt=%0d expected sat=1 cnt=3", d_sat, d_cnt); end
            end
        end
        n_checks++;
        if ({d_sat, d_cnt} !== 3'b000) begin n_fail++; $display("FAIL sat_clr: got sat=%b cnt=%0d expected sat=0 cnt=0", d_sat, d_cnt); end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        logic [6:0] s  = 7'b1101110;
        logic [6:0] ea = 7'b0001000;
        bit         xa;
        do_reset();
        for (int i = 6; i >= 0; i--) begin
            sb_q.push_back(ea[i]);
            drive(1'b1, s[i], 1'b0);
            xa = sb_q.pop_front();
            n_checks++;
            if (a_match !== xa) begin n_fail++; $display("FAIL areset_pre bit%0d: got %b expected %b", 7 - i, a_match, xa); end
        end
        // Assert reset between edges and look before the next rising edge.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({a_match, a_sat, a_filled, a_cnt, a_hist} !== 15'h0) begin
            n_fail++; $display("FAIL areset_immediate: got cnt=%0d hist=%b filled=%b match=%b expected all 0", a_cnt, a_hist, a_filled, a_match);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (a_match !== 1'b0) begin n_fail++; $display("FAIL areset_no_match: got %b expected 0", a_match); end
        n_checks++;
        if (a_filled !== 1'b0) begin n_fail++; $display("FAIL areset_filled: got %b expected 0", a_filled); end
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        y_in = 1'b0;
        clr  = 1'b0;
        test_reset();
        test_basic();
        test_overlap();
        test_zero_pattern();
        test_en_gating();
        test_saturation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
